// File: rtl/cnn_top.sv
// cnn_top: streaming lane-detection CNN for one 32x32 8-bit frame.
// Pipeline: 3x3 vertical-edge conv -> ReLU -> 2x2 max-pool -> column-weighted sum.
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   start_signal        one-cycle pulse, arms/restarts frame capture
//   pixel_valid         pixel_in is valid this cycle
//   pixel_in[7:0]       unsigned pixel, raster order
//   final_result_valid  frame result available (level, registered)
//   final_lane_result   signed 48-bit lane score (registered)
module cnn_top #(
    parameter int unsigned IMG_WIDTH  = 32,
    parameter int unsigned IMG_HEIGHT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_signal,
    input  logic        pixel_valid,
    input  logic [7:0]  pixel_in,
    output logic        final_result_valid,
    output logic [47:0] final_lane_result
);
    localparam int unsigned COL_W     = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W     = $clog2(IMG_HEIGHT);
    localparam int unsigned CNT_W     = COL_W + ROW_W;
    localparam int unsigned POOL_N    = (IMG_WIDTH - 2) / 2;
    localparam int unsigned PJ_W      = COL_W - 1;
    localparam int unsigned SUM_W     = 10;
    localparam int unsigned CONV_W    = 12;
    localparam int unsigned RELU_W    = 10;
    localparam int unsigned PROD_W    = 16;
    localparam int unsigned RES_W     = 48;
    localparam int unsigned FLUSH_CYC = 3;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_WIDTH * IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     pix_cnt_q;
    logic [1:0]           flush_cnt_q;

    logic [7:0]           lb0_q [IMG_WIDTH];   // row r-1
    logic [7:0]           lb1_q [IMG_WIDTH];   // row r-2
    // Two stored window columns (col-2, col-1); the incoming column completes the 3x3.
    logic [7:0]           win_q [3][2];

    logic                 s1_valid_q;
    logic [RELU_W-1:0]    s1_relu_q;
    logic                 s1_row_odd_q;
    logic                 s1_col_odd_q;
    logic [PJ_W-1:0]      s1_pj_q;

    logic [RELU_W-1:0]    h_q;                 // left half of current horizontal pair
    logic [RELU_W-1:0]    rowmax_q [POOL_N];   // pair maxima from the even conv row
    logic                 s2_valid_q;
    logic [RELU_W-1:0]    s2_pool_q;
    logic [PJ_W-1:0]      s2_pj_q;

    logic [RES_W-1:0]     acc_q;

    // Conv on the incoming column, evaluated at pixel acceptance
    logic                 accept;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     cc;
    logic                 conv_ok;
    logic [SUM_W-1:0]     sum_r, sum_l;
    logic signed [CONV_W-1:0] conv;
    logic [RELU_W-1:0]    relu;
    logic [RELU_W-1:0]    hmax, pmax;
    logic signed [RELU_W:0]   pool_s;
    logic signed [PJ_W:0]     wgt;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        accept  = (state_q == STREAM) && pixel_valid && !start_signal;
        col     = pix_cnt_q[COL_W-1:0];
        row     = pix_cnt_q[CNT_W-1:COL_W];
        cc      = COL_W'(col - COL_W'(2));
        conv_ok = (row >= ROW_W'(2)) && (col >= COL_W'(2));
        sum_r   = SUM_W'(lb1_q[col]) + SUM_W'({lb0_q[col], 1'b0}) + SUM_W'(pixel_in);
        sum_l   = SUM_W'(win_q[0][0]) + SUM_W'({win_q[1][0], 1'b0}) + SUM_W'(win_q[2][0]);
        conv    = $signed({2'b00, sum_r}) - $signed({2'b00, sum_l});
        relu    = conv[CONV_W-1] ? '0 : conv[RELU_W-1:0];
        hmax    = (s1_relu_q > h_q) ? s1_relu_q : h_q;
        pmax    = (hmax > rowmax_q[s1_pj_q]) ? hmax : rowmax_q[s1_pj_q];
        pool_s  = $signed({1'b0, s2_pool_q});
        wgt     = $signed({1'b0, s2_pj_q}) - $signed((PJ_W+1)'(POOL_N / 2));
        prod    = pool_s * wgt;
    end

    // Frame control and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            pix_cnt_q          <= '0;
            flush_cnt_q        <= '0;
            final_result_valid <= 1'b0;
            final_lane_result  <= '0;
        end else if (start_signal) begin
            state_q            <= STREAM;
            pix_cnt_q          <= '0;
            flush_cnt_q        <= '0;
            final_result_valid <= 1'b0;
            final_lane_result  <= '0;
        end else begin
            case (state_q)
                STREAM: begin
                    if (pixel_valid) begin
                        pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                        if (pix_cnt_q == LAST_PIX) state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Wait for the conv/pool/accumulate stages to drain
                    if (flush_cnt_q == 2'(FLUSH_CYC)) begin
                        final_lane_result  <= acc_q;
                        final_result_valid <= 1'b1;
                        state_q            <= DONE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 2'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath: line buffers, window, conv/ReLU, pool, accumulate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || start_signal) begin
            for (int i = 0; i < int'(IMG_WIDTH); i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
            for (int j = 0; j < int'(POOL_N); j++) rowmax_q[j] <= '0;
            s1_valid_q   <= 1'b0;
            s1_relu_q    <= '0;
            s1_row_odd_q <= 1'b0;
            s1_col_odd_q <= 1'b0;
            s1_pj_q      <= '0;
            h_q          <= '0;
            s2_valid_q   <= 1'b0;
            s2_pool_q    <= '0;
            s2_pj_q      <= '0;
            acc_q        <= '0;
        end else begin
            s1_valid_q <= accept && conv_ok;
            if (accept) begin
                lb1_q[col]  <= lb0_q[col];
                lb0_q[col]  <= pixel_in;
                win_q[0][0] <= win_q[0][1];
                win_q[1][0] <= win_q[1][1];
                win_q[2][0] <= win_q[2][1];
                win_q[0][1] <= lb1_q[col];
                win_q[1][1] <= lb0_q[col];
                win_q[2][1] <= pixel_in;
                s1_relu_q    <= relu;
                s1_row_odd_q <= row[0];      // conv row r-2 has the same parity
                s1_col_odd_q <= cc[0];
                s1_pj_q      <= cc[COL_W-1:1];
            end

            s2_valid_q <= 1'b0;
            if (s1_valid_q) begin
                if (!s1_col_odd_q) begin
                    h_q <= s1_relu_q;
                end else if (!s1_row_odd_q) begin
                    rowmax_q[s1_pj_q] <= hmax;
                end else begin
                    s2_valid_q <= 1'b1;
                    s2_pool_q  <= pmax;
                    s2_pj_q    <= s1_pj_q;
                end
            end

            if (s2_valid_q) acc_q <= acc_q + RES_W'(prod);
        end
    end
endmodule

// File: tb/tb_cnn_top.sv
// tb_cnn_top: directed self-checking bench for cnn_top.
// Drives synthetic edge frames and compares the lane score with hand-computed values.
module tb_cnn_top;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_signal;
    logic        pixel_valid;
    logic [7:0]  pixel_in;
    logic        final_result_valid;
    logic [47:0] final_lane_result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cnn_top dut (
        .clk                (clk),
        .rst                (rst),
        .start_signal       (start_signal),
        .pixel_valid        (pixel_valid),
        .pixel_in           (pixel_in),
        .final_result_valid (final_result_valid),
        .final_lane_result  (final_lane_result)
    );

    // Frame patterns depend on column only
    function automatic logic [7:0] pix(input int mode, input int c);
        case (mode)
            1:       return (c >= 20) ? 8'hFF : 8'h00;   // rising edge at col 20
            2:       return (c >= 4)  ? 8'hFF : 8'h00;   // rising edge at col 4
            3:       return (c < 20)  ? 8'hFF : 8'h00;   // falling edge at col 20
            4:       return 8'hFF;                       // uniform white
            5:       return (c == 10) ? 8'hFF : 8'h00;   // single bright column
            6:       return (c >= 12) ? 8'hFF : 8'h00;   // rising edge at col 12
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [7:0] px);
        pixel_valid = pv;
        pixel_in    = px;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input logic pv, input logic [7:0] px);
        start_signal = 1'b1;
        pixel_valid  = pv;
        pixel_in     = px;
        @(posedge clk);
        #1;
        start_signal = 1'b0;
        pixel_valid  = 1'b0;
    endtask

    task automatic send_frame(input int mode, input int npix, input bit gaps);
        for (int k = 0; k < npix; k++) begin
            drive(1'b1, pix(mode, k % 32));
            if (gaps && (k % 7 == 6)) repeat (3) drive(1'b0, 8'h00);
        end
        pixel_valid = 1'b0;
        pixel_in    = 8'h00;
    endtask

    // Result must appear within 8 cycles of the last accepted pixel
    task automatic wait_result(input string tag, input logic [47:0] exp);
        int k;
        k = 0;
        while (!final_result_valid && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_valid"}, 48'(final_result_valid), 48'd1);
        check(tag, final_lane_result, exp);
    endtask

    task automatic run_frame(input string tag, input int mode, input bit gaps, input logic [47:0] exp);
        start_pulse(1'b0, 8'h00);
        send_frame(mode, 1024, gaps);
        wait_result(tag, exp);
    endtask

    initial begin
        rst          = 1'b0;
        start_signal = 1'b0;
        pixel_valid  = 1'b0;
        pixel_in     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 48'(final_result_valid), 48'd0);
        check("reset_result", final_lane_result, 48'd0);
        rst = 1'b1;
        drive(1'b0, 8'h00);

        // Pixels before any start are ignored
        send_frame(1, 40, 1'b0);
        check("idle_no_valid", 48'(final_result_valid), 48'd0);

        run_frame("zero_frame",   0, 1'b0, 48'd0);
        run_frame("edge_col20",   1, 1'b0, 48'd30600);
        run_frame("edge_col4",    2, 1'b0, 48'hFFFF_FFFE_9968);
        run_frame("inv_edge",     3, 1'b0, 48'd0);
        run_frame("uniform_ff",   4, 1'b0, 48'd0);
        run_frame("single_col10", 5, 1'b0, -48'sd45900);
        run_frame("edge_col12",   6, 1'b0, -48'sd30600);
        run_frame("edge20_gaps",  1, 1'b1, 48'd30600);

        // Pixel coincident with start is dropped
        start_pulse(1'b1, 8'hFF);
        send_frame(1, 1024, 1'b0);
        wait_result("start_pixel_ignored", 48'd30600);

        // Start mid-frame aborts it
        start_pulse(1'b0, 8'h00);
        send_frame(2, 300, 1'b0);
        run_frame("abort_restart", 1, 1'b0, 48'd30600);

        // Start from DONE: valid drops next cycle, new frame computed, extras ignored
        start_pulse(1'b0, 8'h00);
        check("done_restart_drop", 48'(final_result_valid), 48'd0);
        send_frame(2, 1024, 1'b0);
        wait_result("done_restart_frame", 48'hFFFF_FFFE_9968);
        send_frame(1, 60, 1'b0);
        repeat (10) drive(1'b0, 8'h00);
        check("extra_px_valid", 48'(final_result_valid), 48'd1);
        check("extra_px_result", final_lane_result, 48'hFFFF_FFFE_9968);

        // Reset from DONE clears the held result
        rst = 1'b0;
        #1;
        check("rst_done_valid", 48'(final_result_valid), 48'd0);
        check("rst_done_result", final_lane_result, 48'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 8'h00);

        // Reset mid-frame discards progress and returns to IDLE
        start_pulse(1'b0, 8'h00);
        send_frame(2, 500, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_valid", 48'(final_result_valid), 48'd0);
        check("rst_mid_result", final_lane_result, 48'd0);
        rst = 1'b1;
        drive(1'b0, 8'h00);
        send_frame(1, 1024, 1'b0);
        repeat (10) drive(1'b0, 8'h00);
        check("rst_needs_start", 48'(final_result_valid), 48'd0);
        run_frame("after_reset", 1, 1'b0, 48'd30600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cnn_top.md
# cnn_top

Streaming lane-detection CNN accelerator. It accepts one 32×32 8-bit grayscale frame in raster order after a start pulse, and runs a fixed 3×3 vertical-edge convolution, ReLU, 2×2 max-pool and a fixed column-weighted reduction. The output is one signed 48-bit lane-offset score per frame. It sits between the host pixel interface (Raspberry Pi bridge) and the steering logic.

## Interface
- IMG_WIDTH, 32: pixels per row (fixed; other values not supported)
- IMG_HEIGHT, 32: rows per frame (fixed)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low; one clock, reset is asynchronous and active-low
- start_signal  in  1  one-cycle pulse that arms/restarts frame capture
- pixel_valid  in  1  pixel_in valid this cycle
- pixel_in  in  8  unsigned pixel, raster order (row 0 col 0 first)
- final_result_valid  out  1  frame result available (level)
- final_lane_result  out  48  signed lane score, two's complement

## Operation
- States: IDLE → STREAM (on start_signal) → FLUSH (after 1024th accepted pixel) → DONE (result written) → STREAM on next start_signal.
- Pixel accepted only in STREAM with pixel_valid=1. Pixels in IDLE/FLUSH/DONE are ignored. Gaps in pixel_valid are allowed and stall the pipeline.
- start_signal in any state: clears the pixel counter, line buffers and accumulator, drops final_result_valid and enters STREAM. A start mid-frame aborts that frame.
- Conv: C(r,c) = Σ K[i][j]·p(r+i,c+j), r,c ∈ 0..29 (valid only, no padding). K = [-1 0 1; -2 0 2; -1 0 1]. Range −1020..1020, 12-bit signed.
- Implementation uses two 32-entry row line buffers plus a 3×3 window register.
- ReLU: R = max(0, C), range 0..1020.
- Pool: P(i,j) = max R over rows 2i..2i+1 and cols 2j..2j+1, i,j ∈ 0..14. Needs a 15-entry buffer for per-pair row maxima.
- Reduction: final = Σ P(i,j)·(j−7), accumulated sign-extended to 48 bits with no saturation. Maximum magnitude ≈ 15·15·1020·7 fits easily.
- Result register loads in FLUSH. It holds until the next start_signal or reset.

## Timing
- Reset: final_result_valid=0, final_lane_result=0, state=IDLE, all buffers and the accumulator cleared.
- Reset mid-frame discards all progress. A new start_signal is required afterwards.
- start_signal is sampled on the rising edge. A pixel may be presented with pixel_valid on the cycle after the start pulse.
- If start_signal and pixel_valid are high in the same cycle, that pixel is ignored.
- Latency: final_result_valid rises ≤8 cycles after the 1024th pixel is accepted. final_lane_result is valid in that same cycle.
- final_result_valid stays high in DONE. It clears on the cycle after start_signal is sampled, or on reset.
- Pixels beyond 1024 are ignored, with no wrap into a new frame.

## Test plan
- All-zero frame after start, 1024 continuous pixels → final_result_valid within 8 cycles; final_lane_result = 0.
- Frame with cols 0..19 = 0x00 and cols 20..31 = 0xFF → conv cols 18,19 = 1020, pool col 9 → result = 15·1020·2 = 30600.
- Frame with cols 0..3 = 0x00 and cols 4..31 = 0xFF → pool col 1 → result = 15·1020·(−6) = −91800 (0xFFFFFFFE9968).
- Inverted edge (cols 0..19 = 0xFF, cols 20..31 = 0x00) → all conv negative, ReLU zeroes them → result 0. Uniform 0xFF frame → result 0.
- Edge frame at col 20, with pixel_valid deasserted for 3 cycles after every 7th pixel → result 30600, identical to the continuous case.
- Drive 500 pixels, then assert rst low for 2 cycles; outputs must be 0/0. Then start and send the col-20 edge frame → 30600. Also issue a second start while in DONE: valid must drop, the next frame's result must be correct, and extra pixels after 1024 must not change the result.
